spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI slave that pairs with the team's SPI master: same bus, CPOL/CPHA modes and unit size (8/16 bit), MSB first.
- Oversamples scl/ss/mosi on the system clock, shifts mosi into a 128-bit receive buffer and shifts a 128-bit transmit buffer out on miso.
- Presents the received frame and status to the register/FIFO layer when ss deasserts.

Parameters:
- MODE_16B, 0, unit size: 0 = 8-bit units, 1 = 16-bit units.
- CPOL, 1, scl idle level.
- CPHA, 1, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- slv_wfifo  input  128  transmit data. Bit 127 is sent first. Latched at frame start.
- slv_ctrl  input  8  [7] enable; [6] done_clr (level); [5:0] reserved, ignored.
- slv_rfifo  output  128  received frame. The last bit received is in bit 0.
- slv_status  output  8  [7] busy, [6] done, [5] ovf, [4:0] unit_cnt.
- scl  input  1  SPI clock from master, asynchronous.
- ss  input  1  slave select, active-low, asynchronous.
- mosi  input  1  master data in, asynchronous.
- miso  output  1  slave data out.

Behaviour:
- Reset: all state is cleared on a clk edge with rst=1. slv_rfifo=0, slv_status=0, miso=0, tx/rx shift registers=0, armed=0.
- Synchronizers: scl, ss and mosi each pass through two flops (scl_s, ss_s, mosi_s). One further flop per signal gives edge detect.
- Edge latency: edge events fire 3 clk after the pin change. Master scl half-period must be >= 4 clk; the team master uses 8.
- Edge roles when CPOL==CPHA: sample edge = scl_s rising, shift edge = scl_s falling.
- Edge roles when CPOL!=CPHA: sample edge = scl_s falling, shift edge = scl_s rising.
- Arming: armed sets when ss_s is seen high with enable=1. armed clears when enable=0 (immediate, any state).
- Arming after reset: a frame already in progress is ignored until ss_s returns high.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE: ss_s falling edge while armed=1. In that cycle: tx_buf <= slv_wfifo, bit_cnt <= 0, unit_cnt_int <= 0, ovf_int <= 0, first_shift <= 1.
- ACTIVE -> IDLE on ss_s rising edge. In that cycle: slv_rfifo <= rx_buf, done <= 1, status[5] <= ovf_int, status[4:0] <= unit_cnt_int.
- ACTIVE -> IDLE on enable=0 (abort). No slv_rfifo update, done unchanged.
- Sample edge (ACTIVE): rx_buf <= {rx_buf[126:0], mosi_s}; bit_cnt increments.
- Unit completion: bit_cnt wraps at 8 (16 if MODE_16B). On wrap, unit_cnt_int increments, saturating at 16 (8 in 16-bit mode).
- Overflow: more than 128 bits sampled in one frame sets ovf_int. rx_buf keeps the last 128 bits.
- Shift edge (ACTIVE): tx_buf <= {tx_buf[126:0], 1'b0}. Exception: when CPHA=1 and first_shift=1, there is no shift and first_shift is cleared (the MSB is presented on the leading edge).
- miso: equals tx_buf[127] in ACTIVE, 0 in IDLE. In CPHA=0 modes the MSB is valid 1 clk after the ss_s falling edge, 4 clk after the ss pin.
- busy: slv_status[7] = (state == ACTIVE), combinational from the state flop.
- done_clr: done clears on any cycle where done_clr=1, except a frame-end cycle, where set wins.
- Partial units: partial trailing bits are kept in slv_rfifo but not counted in unit_cnt.
- Empty frame: a frame with 0 scl edges gives slv_rfifo=0, unit_cnt=0, done=1.
- Glitches: scl edges while in IDLE are ignored. A new frame start discards the previous rx_buf (rx_buf is cleared at IDLE -> ACTIVE).

Test Plan:
- CPOL=1, CPHA=1, 8-bit units, slv_wfifo[127:120]=8'hA5. Master sends 8'h5A, scl half-period 8 clk. Required: slv_rfifo[7:0]=8'h5A, miso bits 1,0,1,0,0,1,0,1, status=8'h41 after ss high.
- CPOL=0, CPHA=0: same stimulus. Required: miso=1 within 4 clk of ss falling, before the first scl edge; slv_rfifo[7:0]=8'h5A.
- MODE_16B=1, CPOL=1, CPHA=0: master sends 16'h1234, 16'hABCD. Required: slv_rfifo[31:0]=32'h1234ABCD, unit_cnt=2, ovf=0.
- 17-byte frame (8-bit mode). Required: ovf=1, unit_cnt=16, slv_rfifo holds the last 16 bytes.
- Enable=0 during a frame: scl toggles, frame ends. Required: busy stays 0, miso=0, done stays 0, slv_rfifo unchanged.
- rst=1 for 1 clk mid-frame, then the frame continues. Required: all outputs 0 and no capture for that frame; the next full frame is captured correctly.
- done_clr=1 in the same cycle as the ss rising-edge event. Required: done=1. With done_clr=1 on a later cycle, done=0.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: oversampling SPI slave, MSB first, 8- or 16-bit units.
//
// The SPI pins are asynchronous to clk. They are synchronized and
// edge-detected here. mosi is shifted into a 128-bit receive buffer, and a
// 128-bit transmit buffer is shifted out on miso. When ss deasserts, the
// received frame and its status are presented to the register/FIFO layer.
//
// Parameters:
//   MODE_16B  0 = 8-bit units, 1 = 16-bit units
//   CPOL      idle level of scl
//   CPHA      0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   slv_wfifo   transmit frame; bit 127 is sent first; latched at frame start
//   slv_ctrl    [7] enable, [6] done_clr (level), [5:0] ignored
//   slv_rfifo   received frame; the last bit received is in bit 0
//   slv_status  [7] busy, [6] done, [5] ovf, [4:0] unit_cnt
//   scl/ss/mosi SPI inputs from the master (asynchronous, ss active-low)
//   miso        SPI data out (registered)
module spi_slave #(
    parameter bit MODE_16B = 1'b0,
    parameter bit CPOL     = 1'b1,
    parameter bit CPHA     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] slv_wfifo,
    input  logic [7:0]   slv_ctrl,
    output logic [127:0] slv_rfifo,
    output logic [7:0]   slv_status,
    input  logic         scl,
    input  logic         ss,
    input  logic         mosi,
    output logic         miso
);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    localparam logic [3:0] BIT_LAST   = MODE_16B ? 4'd15 : 4'd7;
    localparam logic [4:0] UNIT_MAX   = MODE_16B ? 5'd8 : 5'd16;
    localparam logic [7:0] SAMPLE_MAX = 8'd128;

    logic [1:0]   scl_sync_r, ss_sync_r, mosi_sync_r;
    logic         scl_d_r, ss_d_r;
    logic         scl_s, ss_s, mosi_s;
    logic         scl_rise_s, scl_fall_s, ss_rise_s, ss_fall_s;
    logic         sample_edge_s, shift_edge_s;
    logic         enable_s, done_clr_s, busy_s;
    logic         unused_ctrl_s;

    state_t       state_r;
    logic         armed_r;
    logic [127:0] tx_buf_r, rx_buf_r, rfifo_r;
    logic [3:0]   bit_cnt_r;
    logic [4:0]   unit_cnt_r, st_unit_r;
    logic [7:0]   sample_cnt_r;
    logic         ovf_r, st_ovf_r, done_r, first_shift_r, miso_r;

    assign scl_s  = scl_sync_r[1];
    assign ss_s   = ss_sync_r[1];
    assign mosi_s = mosi_sync_r[1];

    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign ss_rise_s  = ss_s & ~ss_d_r;
    assign ss_fall_s  = ~ss_s & ss_d_r;

    // CPOL == CPHA samples on the rising scl edge, otherwise on the falling one.
    assign sample_edge_s = (CPOL == CPHA) ? scl_rise_s : scl_fall_s;
    assign shift_edge_s  = (CPOL == CPHA) ? scl_fall_s : scl_rise_s;

    assign enable_s      = slv_ctrl[7];
    assign done_clr_s    = slv_ctrl[6];
    assign unused_ctrl_s = ^slv_ctrl[5:0];

    assign busy_s     = (state_r == ST_ACTIVE);
    assign slv_rfifo  = rfifo_r;
    assign slv_status = {busy_s, done_r, st_ovf_r, st_unit_r};
    assign miso       = miso_r;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r  <= 2'b00;
            ss_sync_r   <= 2'b00;
            mosi_sync_r <= 2'b00;
            scl_d_r     <= 1'b0;
            ss_d_r      <= 1'b0;
        end else begin
            scl_sync_r  <= {scl_sync_r[0], scl};
            ss_sync_r   <= {ss_sync_r[0], ss};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            scl_d_r     <= scl_sync_r[1];
            ss_d_r      <= ss_sync_r[1];
        end
    end

    // Frame FSM: arming, shifting, unit counting and frame-end capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            armed_r       <= 1'b0;
            tx_buf_r      <= 128'd0;
            rx_buf_r      <= 128'd0;
            rfifo_r       <= 128'd0;
            bit_cnt_r     <= 4'd0;
            unit_cnt_r    <= 5'd0;
            st_unit_r     <= 5'd0;
            sample_cnt_r  <= 8'd0;
            ovf_r         <= 1'b0;
            st_ovf_r      <= 1'b0;
            done_r        <= 1'b0;
            first_shift_r <= 1'b0;
            miso_r        <= 1'b0;
        end else begin
            // Arming needs ss seen idle, so a frame already running is skipped.
            if (!enable_s) begin
                armed_r <= 1'b0;
            end else if (ss_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end

            // A frame-end below overrides this clear, so set wins.
            if (done_clr_s) begin
                done_r <= 1'b0;
            end else begin
                done_r <= done_r;
            end

            miso_r <= (state_r == ST_ACTIVE) ? tx_buf_r[127] : 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (enable_s && armed_r && ss_fall_s) begin
                        state_r       <= ST_ACTIVE;
                        tx_buf_r      <= slv_wfifo;
                        rx_buf_r      <= 128'd0;
                        bit_cnt_r     <= 4'd0;
                        unit_cnt_r    <= 5'd0;
                        sample_cnt_r  <= 8'd0;
                        ovf_r         <= 1'b0;
                        first_shift_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable_s) begin
                        // Abort: the partial frame is dropped silently.
                        state_r <= ST_IDLE;
                    end else if (ss_rise_s) begin
                        state_r   <= ST_IDLE;
                        rfifo_r   <= rx_buf_r;
                        done_r    <= 1'b1;
                        st_ovf_r  <= ovf_r;
                        st_unit_r <= unit_cnt_r;
                    end else begin
                        if (sample_edge_s) begin
                            rx_buf_r <= {rx_buf_r[126:0], mosi_s};
                            if (bit_cnt_r == BIT_LAST) begin
                                bit_cnt_r <= 4'd0;
                                if (unit_cnt_r < UNIT_MAX) begin
                                    unit_cnt_r <= unit_cnt_r + 5'd1;
                                end else begin
                                    unit_cnt_r <= unit_cnt_r;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                            // Counter stops at 128; any further sample is overflow.
                            if (sample_cnt_r == SAMPLE_MAX) begin
                                ovf_r <= 1'b1;
                            end else begin
                                sample_cnt_r <= sample_cnt_r + 8'd1;
                            end
                        end else begin
                            rx_buf_r <= rx_buf_r;
                        end
                        if (shift_edge_s) begin
                            // With CPHA=1 the first leading edge only presents the MSB.
                            if ((CPHA == 1'b1) && first_shift_r) begin
                                first_shift_r <= 1'b0;
                            end else begin
                                tx_buf_r      <= {tx_buf_r[126:0], 1'b0};
                                first_shift_r <= 1'b0;
                            end
                        end else begin
                            tx_buf_r <= tx_buf_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. Three instances cover the modes:
//   u0: 8-bit, CPOL=1, CPHA=1    u1: 8-bit, CPOL=0, CPHA=0
//   u2: 16-bit, CPOL=1, CPHA=0
// A behavioural SPI master drives each bus; expected frames, status and miso
// bit streams are computed from the bit list sent and the transmit word.
module tb_spi_slave;

    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] wfifo;
    logic [7:0]   ctrl;
    logic         scl_v  [3];
    logic         ss_v   [3];
    logic         mosi_v [3];
    logic         miso_v [3];
    logic [127:0] rfifo_v  [3];
    logic [7:0]   status_v [3];

    int   n_checks = 0;
    int   n_fail = 0;
    bit   tx_bits[$];
    logic miso_q[$];
    logic miso_at4;
    logic [127:0] exp_rfifo [3];

    logic mon_en = 1'b0;
    int   mon_inst = 0;
    logic busy_seen = 1'b0;
    logic miso_seen = 1'b0;

    always #5 clk = ~clk;

    spi_slave #(.MODE_16B(1'b0), .CPOL(1'b1), .CPHA(1'b1)) u0 (
        .clk(clk), .rst(rst), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rfifo_v[0]), .slv_status(status_v[0]),
        .scl(scl_v[0]), .ss(ss_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]));
    spi_slave #(.MODE_16B(1'b0), .CPOL(1'b0), .CPHA(1'b0)) u1 (
        .clk(clk), .rst(rst), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rfifo_v[1]), .slv_status(status_v[1]),
        .scl(scl_v[1]), .ss(ss_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]));
    spi_slave #(.MODE_16B(1'b1), .CPOL(1'b1), .CPHA(1'b0)) u2 (
        .clk(clk), .rst(rst), .slv_wfifo(wfifo), .slv_ctrl(ctrl),
        .slv_rfifo(rfifo_v[2]), .slv_status(status_v[2]),
        .scl(scl_v[2]), .ss(ss_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]));

    // Accumulates busy and miso activity of one instance while monitoring.
    always @(negedge clk) begin
        if (!mon_en) begin
            busy_seen <= 1'b0;
            miso_seen <= 1'b0;
        end else begin
            busy_seen <= busy_seen | status_v[mon_inst][7];
            miso_seen <= miso_seen | miso_v[mon_inst];
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_bits_random(input int n);
        tx_bits.delete();
        for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic set_bits_value(input logic [31:0] val, input int n);
        tx_bits.delete();
        for (int i = 0; i < n; i++) tx_bits.push_back(val[n - 1 - i]);
    endtask

    task automatic set_wfifo_random();
        wfifo = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Behavioural master: sends tx_bits MSB first, records miso as the master sees it.
    task automatic spi_xfer(input int inst, input int nbits, input bit close);
        bit cpol;
        bit cpha;
        cpol = (inst != 1);
        cpha = (inst == 0);
        miso_q.delete();
        ss_v[inst] = 1'b0;
        if (!cpha && nbits > 0) mosi_v[inst] = tx_bits[0];
        wait_clk(4);
        miso_at4 = miso_v[inst];
        wait_clk(HALF - 4);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                miso_q.push_back(miso_v[inst]);
                scl_v[inst] = ~cpol;
                wait_clk(HALF);
                scl_v[inst] = cpol;
                if (i + 1 < nbits) mosi_v[inst] = tx_bits[i + 1];
                wait_clk(HALF);
            end else begin
                scl_v[inst] = ~cpol;
                mosi_v[inst] = tx_bits[i];
                wait_clk(HALF);
                miso_q.push_back(miso_v[inst]);
                scl_v[inst] = cpol;
                wait_clk(HALF);
            end
        end
        if (close) begin
            ss_v[inst] = 1'b1;
            wait_clk(HALF);
        end
    endtask

    // Frame keeps the last 128 bits sent; the newest bit lands in bit 0.
    function automatic logic [127:0] model_rfifo();
        logic [127:0] r;
        int n;
        r = 128'd0;
        n = tx_bits.size();
        for (int k = 0; k < 128 && k < n; k++) r[k] = tx_bits[n - 1 - k];
        return r;
    endfunction

    function automatic logic [7:0] model_status(input int n, input int unit_bits);
        int units;
        logic [4:0] u5;
        units = n / unit_bits;
        if (units > 128 / unit_bits) units = 128 / unit_bits;
        u5 = units[4:0];
        return {1'b0, 1'b1, (n > 128) ? 1'b1 : 1'b0, u5};
    endfunction

    // Bit i seen by the master is word bit 127-i; zeros after the word runs out.
    function automatic logic [255:0] model_miso(input logic [127:0] wf, input int n);
        logic [255:0] m;
        m = 256'd0;
        for (int i = 0; i < n && i < 128; i++) m[i] = wf[127 - i];
        return m;
    endfunction

    function automatic logic [255:0] pack_miso();
        logic [255:0] m;
        m = 256'd0;
        for (int i = 0; i < miso_q.size() && i < 256; i++) m[i] = miso_q[i];
        return m;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rfifo_v[i] !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_rfifo[%0d]: got %h expected 0", i, rfifo_v[i]);
            end
            n_checks++;
            if (status_v[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_status[%0d]: got %h expected 00", i, status_v[i]);
            end
            n_checks++;
            if (miso_v[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_miso[%0d]: got %b expected 0", i, miso_v[i]);
            end
        end
    endtask

    // Directed frame first, then an empty frame, then random-length frames.
    task automatic test_frames(input int inst);
        int unit_bits;
        int n;
        logic [127:0] exp_r;
        logic [7:0] exp_s;
        logic [255:0] exp_m;
        logic [255:0] got_m;
        unit_bits = (inst == 2) ? 16 : 8;
        for (int it = 0; it < 6; it++) begin
            set_wfifo_random();
            if (it == 0) begin
                if (inst == 2) begin
                    set_bits_value(32'h1234ABCD, 32);
                end else begin
                    wfifo[127:120] = 8'hA5;
                    set_bits_value(32'h0000005A, 8);
                end
            end else if (it == 1) begin
                tx_bits.delete();
            end else begin
                set_bits_random($urandom_range(1, 70));
            end
            n = tx_bits.size();
            spi_xfer(inst, n, 1'b1);
            exp_r = model_rfifo();
            exp_s = model_status(n, unit_bits);
            exp_m = model_miso(wfifo, n);
            got_m = pack_miso();
            n_checks++;
            if (rfifo_v[inst] !== exp_r) begin
                n_fail++;
                $display("FAIL frame_rfifo u%0d it%0d n=%0d: got %h expected %h", inst, it, n, rfifo_v[inst], exp_r);
            end
            n_checks++;
            if (status_v[inst] !== exp_s) begin
                n_fail++;
                $display("FAIL frame_status u%0d it%0d n=%0d: got %h expected %h", inst, it, n, status_v[inst], exp_s);
            end
            n_checks++;
            if (got_m !== exp_m) begin
                n_fail++;
                $display("FAIL frame_miso u%0d it%0d n=%0d: got %h expected %h", inst, it, n, got_m, exp_m);
            end
            exp_rfifo[inst] = exp_r;
            if (it == 0 && inst != 2) begin
                n_checks++;
                if (rfifo_v[inst][7:0] !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL directed_byte u%0d: got %h expected 5a", inst, rfifo_v[inst][7:0]);
                end
                n_checks++;
                if (status_v[inst] !== 8'h41) begin
                    n_fail++;
                    $display("FAIL directed_status u%0d: got %h expected 41", inst, status_v[inst]);
                end
                n_checks++;
                if (got_m[7:0] !== 8'b10100101) begin
                    n_fail++;
                    $display("FAIL directed_miso u%0d: got %b expected 10100101 (bit0 first)", inst, got_m[7:0]);
                end
            end
            if (it == 0 && inst == 1) begin
                n_checks++;
                if (miso_at4 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cpha0_msb_early: got %b expected 1", miso_at4);
                end
            end
            if (it == 0 && inst == 2) begin
                n_checks++;
                if (rfifo_v[2][31:0] !== 32'h1234ABCD) begin
                    n_fail++;
                    $display("FAIL mode16_words: got %h expected 1234abcd", rfifo_v[2][31:0]);
                end
                n_checks++;
                if (status_v[2][5:0] !== 6'd2) begin
                    n_fail++;
                    $display("FAIL mode16_ovf_units: got %h expected 02", status_v[2][5:0]);
                end
            end
            wait_clk(4);
        end
    endtask

    task automatic test_overflow();
        logic [127:0] exp_r;
        logic [255:0] exp_m;
        logic [255:0] got_m;
        set_wfifo_random();
        set_bits_random(136);
        spi_xfer(0, 136, 1'b1);
        exp_r = model_rfifo();
        exp_m = model_miso(wfifo, 136);
        got_m = pack_miso();
        n_checks++;
        if (status_v[0][5] !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b expected 1", status_v[0][5]);
        end
        n_checks++;
        if (status_v[0][4:0] !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_units: got %0d expected 16", status_v[0][4:0]);
        end
        n_checks++;
        if (rfifo_v[0] !== exp_r) begin
            n_fail++;
            $display("FAIL ovf_rfifo: got %h expected %h", rfifo_v[0], exp_r);
        end
        n_checks++;
        if (got_m !== exp_m) begin
            n_fail++;
            $display("FAIL ovf_miso: got %h expected %h", got_m, exp_m);
        end
        exp_rfifo[0] = exp_r;
        wait_clk(4);
    endtask

    task automatic test_disable();
        ctrl = 8'hC0;
        wait_clk(1);
        ctrl = 8'h00;
        wait_clk(3);
        set_wfifo_random();
        wfifo[127] = 1'b1;
        wfifo[125] = 1'b1;
        set_bits_random(24);
        mon_inst = 0;
        mon_en = 1'b1;
        wait_clk(1);
        spi_xfer(0, 24, 1'b1);
        n_checks++;
        if (busy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_busy: got %b expected 0", busy_seen);
        end
        n_checks++;
        if (miso_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_miso: got %b expected 0", miso_seen);
        end
        n_checks++;
        if (status_v[0][6] !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_done: got %b expected 0", status_v[0][6]);
        end
        n_checks++;
        if (rfifo_v[0] !== exp_rfifo[0]) begin
            n_fail++;
            $display("FAIL disable_rfifo: got %h expected %h", rfifo_v[0], exp_rfifo[0]);
        end
        mon_en = 1'b0;
        ctrl = 8'h80;
        wait_clk(4);
    endtask

    task automatic test_done_clr();
        logic [127:0] exp_r;
        ctrl = 8'hC0;
        wait_clk(1);
        ctrl = 8'h80;
        set_wfifo_random();
        set_bits_random(16);
        spi_xfer(0, 16, 1'b0);
        ss_v[0] = 1'b1;
        // The ss rising-edge event lands on the third clk edge after the pin.
        wait_clk(2);
        ctrl = 8'hC0;
        wait_clk(1);
        ctrl = 8'h80;
        exp_r = model_rfifo();
        n_checks++;
        if (status_v[0][6] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_set_wins: got %b expected 1", status_v[0][6]);
        end
        n_checks++;
        if (rfifo_v[0] !== exp_r) begin
            n_fail++;
            $display("FAIL done_clr_rfifo: got %h expected %h", rfifo_v[0], exp_r);
        end
        exp_rfifo[0] = exp_r;
        wait_clk(5);
        n_checks++;
        if (status_v[0][6] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: got %b expected 1", status_v[0][6]);
        end
        ctrl = 8'hC0;
        wait_clk(1);
        ctrl = 8'h80;
        n_checks++;
        if (status_v[0][6] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: got %b expected 0", status_v[0][6]);
        end
        wait_clk(4);
    endtask

    task automatic test_reset_midframe();
        logic [127:0] exp_r;
        logic [7:0] exp_s;
        logic [255:0] exp_m;
        logic [255:0] got_m;
        set_wfifo_random();
        set_bits_random(32);
        fork
            spi_xfer(0, 32, 1'b1);
            begin
                wait_clk(60);
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                n_checks++;
                if (rfifo_v[0] !== 128'd0 || status_v[0] !== 8'h00 || miso_v[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_outputs: got rfifo=%h status=%h miso=%b expected all 0", rfifo_v[0], status_v[0], miso_v[0]);
                end
            end
        join
        for (int i = 0; i < 3; i++) exp_rfifo[i] = 128'd0;
        n_checks++;
        if (status_v[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_no_capture_status: got %h expected 00", status_v[0]);
        end
        n_checks++;
        if (rfifo_v[0] !== 128'd0) begin
            n_fail++;
            $display("FAIL midrst_no_capture_rfifo: got %h expected 0", rfifo_v[0]);
        end
        wait_clk(4);
        set_wfifo_random();
        set_bits_random(24);
        spi_xfer(0, 24, 1'b1);
        exp_r = model_rfifo();
        exp_s = model_status(24, 8);
        exp_m = model_miso(wfifo, 24);
        got_m = pack_miso();
        n_checks++;
        if (rfifo_v[0] !== exp_r) begin
            n_fail++;
            $display("FAIL midrst_next_rfifo: got %h expected %h", rfifo_v[0], exp_r);
        end
        n_checks++;
        if (status_v[0] !== exp_s) begin
            n_fail++;
            $display("FAIL midrst_next_status: got %h expected %h", status_v[0], exp_s);
        end
        n_checks++;
        if (got_m !== exp_m) begin
            n_fail++;
            $display("FAIL midrst_next_miso: got %h expected %h", got_m, exp_m);
        end
    endtask

    initial begin
        rst = 1'b1;
        ctrl = 8'h00;
        wfifo = 128'd0;
        scl_v[0] = 1'b1; scl_v[1] = 1'b0; scl_v[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ss_v[i] = 1'b1;
            mosi_v[i] = 1'b0;
            exp_rfifo[i] = 128'd0;
        end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);
        test_reset();
        ctrl = 8'h80;
        wait_clk(4);
        test_frames(0);
        test_frames(1);
        test_frames(2);
        test_overflow();
        test_disable();
        test_done_clr();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
